// File: rtl/conf_pkg.sv
// -----------------------------------------------------------------------------
// conf_pkg
// Shared definitions for the DRSSTC configuration loader and the UART side
// that produces the per-byte parameter index.
//   PAR_N / PAR_W : parameters per frame / bits per parameter
//   IDX_W         : width of a parameter index (width of PAR_N-1)
//   state_e       : collect FSM states
//   conf_par_e    : parameter index names, shared with the receiver
//   par_bank_t    : packed parameter bank, index i at bits [8i+7:8i]
// -----------------------------------------------------------------------------
package conf_pkg;

    localparam int PAR_N = 5;
    localparam int PAR_W = 8;
    localparam int IDX_W = $clog2(PAR_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_e;

    typedef enum logic [IDX_W-1:0] {
        CONF_PAR_0,
        CONF_PAR_1,
        CONF_PAR_2,
        CONF_PAR_3,
        CONF_PAR_4
    } conf_par_e;

    typedef logic [PAR_N-1:0][PAR_W-1:0] par_bank_t;

    // A frame is sent highest index first.
    localparam logic [IDX_W-1:0] IDX_FIRST  = CONF_PAR_4;
    localparam logic [IDX_W-1:0] IDX_SECOND = CONF_PAR_3;

endpackage

// File: rtl/gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Counts idle cycles between received bytes and flags when the gap reaches
// TIMEOUT_MAX. The counter saturates so a long idle period never wraps back
// into the valid range.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clear   : restart the count at zero (takes priority over enable)
//   enable  : count this cycle
//   expired : level, high while the count equals TIMEOUT_MAX, until clear
// -----------------------------------------------------------------------------
module gap_timer #(
    parameter int TIMEOUT_MAX = 2047
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W   = $clog2(TIMEOUT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_MAX);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/conf_loader.sv
// -----------------------------------------------------------------------------
// conf_loader
// Assembles a 5-byte configuration frame (index 4 first, down to 0), checks
// byte order and inter-byte gap, stages a complete frame and commits it to
// the active parameter bank only inside the interrupter's safe window.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx_data    : received byte, valid with rx_valid
//   rx_addr    : parameter index of rx_data, valid with rx_valid
//   rx_valid   : single-cycle byte strobe
//   commit_ok  : safe-window level, 1 = par_bus may change
//   par_bus    : active parameter bank, index i at bits [8i+7:8i]
//   cfg_update : pulse in the cycle after par_bus was loaded
//   pending    : a validated frame is staged, waiting for commit_ok
//   frame_err  : pulse when a frame or stray byte is discarded
//   overrun    : pulse when an uncommitted staged frame is replaced
//   collecting : a frame is partially received
// -----------------------------------------------------------------------------
module conf_loader
    import conf_pkg::*;
#(
    parameter int                       TIMEOUT_MAX = 2047,
    parameter logic [PAR_N*PAR_W-1:0]   PAR_DEF     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PAR_W-1:0]         rx_data,
    input  logic [IDX_W-1:0]         rx_addr,
    input  logic                     rx_valid,
    input  logic                     commit_ok,
    output logic [PAR_N*PAR_W-1:0]   par_bus,
    output logic                     cfg_update,
    output logic                     pending,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     collecting
);

    state_e           state;
    logic [IDX_W-1:0] exp_idx;
    par_bank_t        col_buf;
    par_bank_t        stage_buf;
    logic             commit_q;

    logic             commit;
    logic             start_hit;
    logic             gap_expired;

    assign commit     = pending && commit_ok;
    assign start_hit  = rx_valid && (rx_addr == IDX_FIRST);
    assign collecting = (state == S_COLLECT);

    // The gap only counts while a frame is open; any byte or leaving the
    // collect state restarts it.
    gap_timer #(
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || (state != S_COLLECT)),
        .enable  ((state == S_COLLECT) && !rx_valid),
        .expired (gap_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            exp_idx    <= IDX_FIRST;
            // NOTE: the frame buffers are plain flops, not a memory array, so
            // they take the reset like every other register.
            col_buf    <= '0;
            stage_buf  <= '0;
            par_bus    <= PAR_DEF;
            pending    <= 1'b0;
            commit_q   <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            commit_q   <= commit;
            cfg_update <= commit_q;

            // Commit always takes the frame staged before this edge.
            if (commit) begin
                par_bus <= stage_buf;
                pending <= 1'b0;
            end

            // Hand-off cycle; a same-cycle commit keeps pending set because the
            // new frame replaces the one just committed.
            if (state == S_DONE) begin
                stage_buf <= col_buf;
                pending   <= 1'b1;
                overrun   <= pending && !commit_ok;
                state     <= S_IDLE;
                exp_idx   <= IDX_FIRST;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_hit) begin
                        col_buf[PAR_N-1] <= rx_data;
                        exp_idx          <= IDX_SECOND;
                        state            <= S_COLLECT;
                    end else if (rx_valid) begin
                        frame_err <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (gap_expired) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                        exp_idx   <= IDX_FIRST;
                    end else if (rx_valid) begin
                        if (rx_addr == exp_idx) begin
                            for (int i = 0; i < PAR_N; i++) begin
                                if (exp_idx == IDX_W'(i)) col_buf[i] <= rx_data;
                            end
                            if (exp_idx == '0) begin
                                state <= S_DONE;
                            end else begin
                                exp_idx <= exp_idx - 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            if (start_hit) begin
                                col_buf[PAR_N-1] <= rx_data;
                                exp_idx          <= IDX_SECOND;
                            end else begin
                                state   <= S_IDLE;
                                exp_idx <= IDX_FIRST;
                            end
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    exp_idx <= IDX_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conf_loader.sv
// -----------------------------------------------------------------------------
// tb_conf_loader
// Self-checking bench for conf_loader: a hand-derived vector table, directed
// multi-cycle sequences, and randomized traffic compared every cycle against a
// frame-level reference model built on a byte queue.
// -----------------------------------------------------------------------------
module tb_conf_loader;
    import conf_pkg::*;

    localparam int          TMO     = 2047;
    localparam logic [39:0] DEF_BUS = 40'h0;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic [2:0]  rx_addr;
    logic        rx_valid;
    logic        commit_ok;
    logic [39:0] par_bus;
    logic        cfg_update;
    logic        pending;
    logic        frame_err;
    logic        overrun;
    logic        collecting;

    conf_loader #(
        .TIMEOUT_MAX (TMO),
        .PAR_DEF     (DEF_BUS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_addr    (rx_addr),
        .rx_valid   (rx_valid),
        .commit_ok  (commit_ok),
        .par_bus    (par_bus),
        .cfg_update (cfg_update),
        .pending    (pending),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .collecting (collecting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;
    int ovr_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_frame holds the bytes of the open frame in arrival order (index 4
    // first). m_done marks the cycle right after the last byte arrived.
    logic [39:0] m_par, m_stage;
    logic [7:0]  m_frame[$];
    bit          m_in_frame, m_done, m_pending, m_commit_q;
    int          m_gap;
    bit          m_err, m_ovr, m_cfg;

    function automatic logic [39:0] pack_frame();
        logic [39:0] f = '0;
        foreach (m_frame[k]) f = {f[31:0], m_frame[k]};
        return f;
    endfunction

    function automatic void model_step(bit r, bit v, logic [2:0] a, logic [7:0] d, bit cok);
        bit commit;
        int want;
        if (r) begin
            m_par = DEF_BUS; m_stage = '0; m_frame.delete();
            m_in_frame = 0; m_done = 0; m_pending = 0; m_commit_q = 0; m_gap = 0;
            m_err = 0; m_ovr = 0; m_cfg = 0;
            return;
        end
        commit     = m_pending && cok;
        m_err      = 0;
        m_ovr      = 0;
        m_cfg      = m_commit_q;
        m_commit_q = commit;
        if (commit) m_par = m_stage;
        if (m_done) begin
            if (m_pending && !commit) m_ovr = 1;
            m_stage   = pack_frame();
            m_pending = 1;
            m_done    = 0;
            m_frame.delete();
        end else if (commit) begin
            m_pending = 0;
        end
        if (m_in_frame) begin
            if (m_gap >= TMO) begin
                m_err = 1; m_in_frame = 0; m_frame.delete();
            end else if (v) begin
                want = PAR_N - 1 - m_frame.size();
                if (int'(a) == want) begin
                    m_frame.push_back(d);
                    m_gap = 0;
                    if (m_frame.size() == PAR_N) begin
                        m_in_frame = 0; m_done = 1;
                    end
                end else begin
                    m_err = 1; m_frame.delete(); m_in_frame = 0;
                    if (int'(a) == PAR_N - 1) begin
                        m_frame.push_back(d); m_in_frame = 1; m_gap = 0;
                    end
                end
            end else begin
                m_gap++;
            end
        end else if (v) begin
            if (int'(a) == PAR_N - 1) begin
                m_frame.delete(); m_frame.push_back(d); m_in_frame = 1; m_gap = 0;
            end else begin
                m_err = 1;
            end
        end
    endfunction

    // One clock: apply inputs, advance model, compare all outputs after edge.
    task automatic drive(input bit r, input bit v, input logic [2:0] a, input logic [7:0] d,
                         input bit cok, input string tag);
        rst = r; rx_valid = v; rx_addr = a; rx_data = d; commit_ok = cok;
        model_step(r, v, a, d, cok);
        @(posedge clk); #1;
        check(tag, {19'h0, par_bus, pending, frame_err, overrun, cfg_update, collecting},
                   {19'h0, m_par, m_pending, m_err, m_ovr, m_cfg, m_in_frame});
        if (frame_err) err_cnt++;
        if (overrun) ovr_cnt++;
    endtask

    task automatic idle(input int n, input bit cok, input string tag);
        repeat (n) drive(0, 0, 3'd0, 8'h00, cok, tag);
    endtask

    task automatic send_frame(input logic [39:0] f, input int gap, input bit cok, input string tag);
        for (int i = PAR_N - 1; i >= 0; i--) begin
            drive(0, 1, 3'(i), f[i*8 +: 8], cok, tag);
            if (i != 0) idle(gap, cok, tag);
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 3'd0, 8'h00, 0, "reset");
        err_cnt = 0;
        ovr_cnt = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          v;
        logic [2:0]  a;
        logic [7:0]  d;
        bit          cok;
        logic [39:0] par;
        bit          pend, err, ovr, cfg, coll;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [2:0]  ra;
        bit          rv, rc, rr;

        rst = 1'b1; rx_valid = 1'b0; rx_addr = '0; rx_data = '0; commit_ok = 1'b0;

        // Frame at full rate with the window open, then stray/misordered bytes.
        tbl[0]  = '{1, 3'd4, 8'hA5, 1, 40'h0,          0, 0, 0, 0, 1};
        tbl[1]  = '{1, 3'd3, 8'h5A, 1, 40'h0,          0, 0, 0, 0, 1};
        tbl[2]  = '{1, 3'd2, 8'h3C, 1, 40'h0,          0, 0, 0, 0, 1};
        tbl[3]  = '{1, 3'd1, 8'hC3, 1, 40'h0,          0, 0, 0, 0, 1};
        tbl[4]  = '{1, 3'd0, 8'h01, 1, 40'h0,          0, 0, 0, 0, 0};
        tbl[5]  = '{0, 3'd0, 8'h00, 1, 40'h0,          1, 0, 0, 0, 0};
        tbl[6]  = '{0, 3'd0, 8'h00, 1, 40'hA55A3CC301, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 3'd0, 8'h00, 1, 40'hA55A3CC301, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 3'd0, 8'h00, 1, 40'hA55A3CC301, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 3'd2, 8'h11, 1, 40'hA55A3CC301, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 3'd0, 8'h00, 1, 40'hA55A3CC301, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 3'd4, 8'hFF, 1, 40'hA55A3CC301, 0, 0, 0, 0, 1};
        tbl[12] = '{1, 3'd4, 8'hEE, 1, 40'hA55A3CC301, 0, 1, 0, 0, 1};
        tbl[13] = '{1, 3'd2, 8'h22, 1, 40'hA55A3CC301, 0, 1, 0, 0, 0};
        tbl[14] = '{0, 3'd0, 8'h00, 1, 40'hA55A3CC301, 0, 0, 0, 0, 0};

        do_reset();
        check("reset_outputs", {19'h0, par_bus, pending, frame_err, overrun, cfg_update, collecting},
                               {19'h0, DEF_BUS, 5'b00000});

        for (int i = 0; i < 15; i++) begin
            rst = 0; rx_valid = tbl[i].v; rx_addr = tbl[i].a; rx_data = tbl[i].d; commit_ok = tbl[i].cok;
            @(posedge clk); #1;
            check($sformatf("table[%0d]", i),
                  {19'h0, par_bus, pending, frame_err, overrun, cfg_update, collecting},
                  {19'h0, tbl[i].par, tbl[i].pend, tbl[i].err, tbl[i].ovr, tbl[i].cfg, tbl[i].coll});
        end

        // Slow frame, window open.
        do_reset();
        send_frame(40'hA55A3CC301, 519, 1, "t1");
        idle(3, 1, "t1");
        check("t1_par", par_bus, 40'hA55A3CC301);
        check("t1_cfg", cfg_update, 1);
        check("t1_pend", pending, 0);
        check("t1_no_err", err_cnt, 0);

        // Window closed: frame waits, then commits when window opens.
        do_reset();
        send_frame(40'hA55A3CC301, 519, 0, "t2");
        idle(1, 0, "t2");
        check("t2_pend", pending, 1);
        idle(100, 0, "t2");
        check("t2_par_held", par_bus, DEF_BUS);
        idle(1, 1, "t2");
        check("t2_par", par_bus, 40'hA55A3CC301);
        idle(1, 1, "t2");
        check("t2_cfg", cfg_update, 1);

        // Skipped index.
        do_reset();
        drive(0, 1, 3'd4, 8'h10, 1, "t3");
        drive(0, 1, 3'd3, 8'h20, 1, "t3");
        drive(0, 1, 3'd1, 8'h30, 1, "t3");
        check("t3_err", frame_err, 1);
        check("t3_idle", collecting, 0);
        send_frame(40'h1122334455, 3, 1, "t3");
        idle(3, 1, "t3");
        check("t3_par", par_bus, 40'h1122334455);

        // Gap timeout, then late bytes rejected.
        do_reset();
        drive(0, 1, 3'd4, 8'h77, 0, "t4");
        drive(0, 1, 3'd3, 8'h66, 0, "t4");
        idle(2100, 0, "t4");
        check("t4_timeout_err", err_cnt, 1);
        check("t4_idle", collecting, 0);
        drive(0, 1, 3'd2, 8'h55, 0, "t4");
        drive(0, 1, 3'd1, 8'h44, 0, "t4");
        drive(0, 1, 3'd0, 8'h33, 0, "t4");
        check("t4_late_err", err_cnt, 4);
        check("t4_pend", pending, 0);

        // Overrun: second frame replaces the first.
        do_reset();
        send_frame(40'hC0C1C2C3C4, 2, 0, "t5");
        idle(2, 0, "t5");
        send_frame(40'hD0D1D2D3D4, 2, 0, "t5");
        idle(1, 0, "t5");
        check("t5_overrun", overrun, 1);
        idle(1, 0, "t5");
        check("t5_ovr_count", ovr_cnt, 1);
        idle(1, 1, "t5");
        check("t5_par", par_bus, 40'hD0D1D2D3D4);

        // Reset mid-frame and while pending.
        do_reset();
        send_frame(40'hE0E1E2E3E4, 1, 1, "t6");
        idle(3, 1, "t6");
        drive(0, 1, 3'd4, 8'h99, 1, "t6");
        drive(0, 1, 3'd3, 8'h98, 1, "t6");
        drive(1, 0, 3'd0, 8'h00, 1, "t6");
        check("t6a_reset", {par_bus, pending, collecting}, {DEF_BUS, 2'b00});
        send_frame(40'hF0F1F2F3F4, 1, 0, "t6");
        idle(2, 0, "t6");
        drive(1, 0, 3'd0, 8'h00, 0, "t6");
        check("t6b_reset", {par_bus, pending, collecting}, {DEF_BUS, 2'b00});
        send_frame(40'h0123456789, 1, 1, "t6");
        idle(3, 1, "t6");
        check("t6_par", par_bus, 40'h0123456789);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rv = ($urandom_range(2) == 0);
            if ($urandom_range(9) < 8)
                ra = m_in_frame ? 3'(PAR_N - 1 - m_frame.size()) : 3'(PAR_N - 1);
            else
                ra = 3'($urandom_range(7));
            rc = ($urandom_range(3) == 0);
            rr = ($urandom_range(999) == 0);
            drive(rr, rv, ra, 8'($urandom), rc, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
